sobel_frame_arbiter: RTL
========================

// Module: sobel_frame_arbiter
// PURPOSE
//  Shares one streaming sobel/conv2d filter between two pixel sources at frame granularity.
//  Round-robin grants a whole frame to one source and forwards it to the filter with zero
//  latency. Tags each filter output with its source id (sid) and marks frame first/last.
//  Sits between the two capture front-ends and the sobel input; receives the sobel output back.
// PARAMETERS
//  width_in_p      8    source pixel width (filter input)
//  width_out_p     16   filter result width
//  linewidth_px_p  480  pixels per line
//  lines_p         480  lines per frame; frame_px = linewidth_px_p*lines_p
//  tag_depth_p     2    frames in flight (granted, outputs not yet fully returned); power of 2
// PORTS
//  clk_i        in   1            clock, all logic on rising edge
//  reset_n_i    in   1            synchronous, active-low reset
//  s0_valid_i   in   1            source 0 pixel valid
//  s0_ready_o   out  1            source 0 ready
//  s0_data_i    in   width_in_p   source 0 pixel
//  s1_valid_i   in   1            source 1 pixel valid
//  s1_ready_o   out  1            source 1 ready
//  s1_data_i    in   width_in_p   source 1 pixel
//  filt_valid_o out  1            to filter valid_i
//  filt_ready_i in   1            from filter ready_o
//  filt_data_o  out  width_in_p   to filter data_i
//  filt_valid_i in   1            from filter valid_o
//  filt_ready_o out  1            to filter ready_i
//  filt_data_i  in   width_out_p  from filter data_o
//  res_valid_o  out  1            tagged result valid
//  res_ready_i  in   1            downstream ready
//  res_data_o   out  width_out_p  result = filt_data_i
//  res_sid_o    out  1            source id of the result's frame
//  res_first_o  out  1            first result of a frame
//  res_last_o   out  1            last result of a frame
//  busy_o       out  1            state==STREAM or tag FIFO non-empty
// BEHAVIOUR
//  Reset (reset_n_i==0 at clk edge): state=IDLE, rr pointer prefers s0, in_cnt=out_cnt=0,
//   tag FIFO empty. All valid/ready outputs 0 and busy_o=0 while in reset and right after it.
//   Reset mid-frame discards the partial frame. The filter shares this reset.
//  FSM IDLE: if tag FIFO not full and any sX_valid_i, grant = rr choice (both valid -> the
//   pointer's source; one valid -> that one). Push grant sid into the tag FIFO, go to STREAM.
//   This is a decision cycle: no pixel transfers in IDLE. All ready_o = 0.
//  FSM STREAM: filt_valid_o=sG_valid_i, filt_data_o=sG_data_i, sG_ready_o=filt_ready_i, the
//   other source's ready=0 (combinational pass-through, 0 latency). in_cnt++ per filter-input
//   handshake. On the handshake with in_cnt==frame_px-1: in_cnt<=0, rr pointer <= other sid,
//   next state IDLE. No mid-frame switching ever.
//  Output side, independent of FSM: filt_ready_o = res_ready_i & tag_nonempty.
//   res_valid_o = filt_valid_i & tag_nonempty. res_sid_o = FIFO head.
//   res_first_o = (out_cnt==0). res_last_o = (out_cnt==frame_px-1).
//   On a res handshake, out_cnt++. On the last one: out_cnt<=0 and the tag FIFO pops.
//  Filter outputs with the tag FIFO empty are back-pressured (never dropped).
//  Push (IDLE grant) and pop (last result) in the same cycle are both honoured; occupancy unchanged.
//  Filter is 1:1 pixels in:out, so out_cnt tracks in_cnt frames in order.
//  Counter widths: $clog2(frame_px). Compares are exact; no wrap beyond frame_px-1.
// STRUCTURE
//  sobel_pkg: typedef enum logic [0:0] {IDLE, STREAM} arb_state_e; typedef logic [0:0] sid_t.
//  Sub-module sid_fifo (sid_t, depth tag_depth_p): push/pop/full/empty/head, registered
//   pointers, simultaneous push+pop allowed even when full-pop/empty-push edge.
// TESTING (linewidth_px_p=4, lines_p=3, frame_px=12)
//  1 Only s0 streams 12 px 0..11, res_ready_i=1: s1_ready_o stays 0. Results tagged sid=0,
//    first on result 0, last on result 11. Tag pops, busy_o falls.
//  2 Both valid from reset: frames granted s0,s1,s0,s1. Each grant is preceded by exactly one
//    IDLE cycle with both readys 0.
//  3 res_ready_i=0 throughout: after 2 frames are granted the FIFO is full. Third grant is
//    withheld in IDLE. Raising res_ready_i releases it only after frame 1's last result pops.
//  4 Random filt_ready_i/res_ready_i/source-valid gaps: result stream equals the input frames
//    in order with correct sid/first/last and no loss or duplication.
//  5 reset_n_i low for 1 cycle at in_cnt=5: next cycle IDLE, FIFO empty, s0 preferred, all
//    counters 0. The next frame is tagged first at result 0.
//  6 Same-cycle push+pop: frame 2 grant coincides with frame 1's last result. Occupancy stays 1
//    and sids are correct.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types for the frame-granular sobel input arbiter.
package sobel_pkg;

  typedef enum logic [0:0] {IDLE, STREAM} arb_state_e;

  typedef logic [0:0] sid_t;

endpackage

// File: rtl/sid_fifo.sv
// Small FIFO holding the source id of every frame granted but not yet fully returned.
module sid_fifo
  import sobel_pkg::*;
#(
  parameter int unsigned depth_p = 2  // power of 2, at least 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic push_i,
  input  sid_t push_sid_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output sid_t head_o
);

  localparam int unsigned PtrW = $clog2(depth_p);
  localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

  // Extra MSB on each pointer tells full from empty when the indices match.
  logic [PtrW:0] wr_q, rd_q;
  sid_t          mem_q [depth_p];
  logic          do_push, do_pop;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    head_o  = mem_q[rd_q[PtrW-1:0]];
    // A pop frees the slot in the same cycle, so push is honoured even when full.
    do_push = push_i & (~full_o | pop_i);
    do_pop  = pop_i & ~empty_o;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrOne;
      if (do_pop)  rd_q <= rd_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[PtrW-1:0]] <= push_sid_i;
  end

endmodule

// File: rtl/sobel_frame_arbiter.sv
// Round-robin, whole-frame sharing of one streaming sobel filter between two pixel sources;
// tags each filter result with its source id and frame first/last markers.
module sobel_frame_arbiter
  import sobel_pkg::*;
#(
  parameter int unsigned width_in_p     = 8,
  parameter int unsigned width_out_p    = 16,
  parameter int unsigned linewidth_px_p = 480,
  parameter int unsigned lines_p        = 480,
  parameter int unsigned tag_depth_p    = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   s0_valid_i,
  output logic                   s0_ready_o,
  input  logic [width_in_p-1:0]  s0_data_i,
  input  logic                   s1_valid_i,
  output logic                   s1_ready_o,
  input  logic [width_in_p-1:0]  s1_data_i,
  output logic                   filt_valid_o,
  input  logic                   filt_ready_i,
  output logic [width_in_p-1:0]  filt_data_o,
  input  logic                   filt_valid_i,
  output logic                   filt_ready_o,
  input  logic [width_out_p-1:0] filt_data_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [width_out_p-1:0] res_data_o,
  output logic                   res_sid_o,
  output logic                   res_first_o,
  output logic                   res_last_o,
  output logic                   busy_o
);

  localparam int unsigned FramePx = linewidth_px_p * lines_p;
  localparam int unsigned CntW    = $clog2(FramePx);
  localparam logic [CntW-1:0] LastCnt = CntW'(FramePx - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  arb_state_e      state_q, state_d;
  sid_t            gnt_q, gnt_d;
  sid_t            rr_q, rr_d;
  logic [CntW-1:0] in_cnt_q, in_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;

  logic push, pop, fifo_full, fifo_empty, tag_nonempty;
  logic src_valid, fv, r0, r1, res_v, res_hs;
  sid_t head_sid;

  sid_fifo #(
    .depth_p (tag_depth_p)
  ) u_sid_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .push_i     (push),
    .push_sid_i (gnt_d),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head_sid)
  );

  // Input side: grant decision in IDLE, zero-latency pass-through in STREAM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    in_cnt_d  = in_cnt_q;
    push      = 1'b0;
    fv        = 1'b0;
    r0        = 1'b0;
    r1        = 1'b0;
    src_valid = gnt_q[0] ? s1_valid_i : s0_valid_i;
    unique case (state_q)
      IDLE: begin
        if (!fifo_full && (s0_valid_i || s1_valid_i)) begin
          gnt_d   = (s0_valid_i && s1_valid_i) ? rr_q : sid_t'(!s0_valid_i);
          push    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        fv = src_valid;
        r0 = ~gnt_q[0] & filt_ready_i;
        r1 = gnt_q[0] & filt_ready_i;
        if (src_valid && filt_ready_i) begin
          if (in_cnt_q == LastCnt) begin
            in_cnt_d = '0;
            rr_d     = ~gnt_q;
            state_d  = IDLE;
          end else begin
            in_cnt_d = in_cnt_q + CntOne;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output side runs independently of the FSM; results wait until a tag is present.
  always_comb begin
    tag_nonempty = ~fifo_empty;
    res_v        = filt_valid_i & tag_nonempty;
    res_hs       = res_v & res_ready_i;
    pop          = res_hs & (out_cnt_q == LastCnt);
    out_cnt_d    = out_cnt_q;
    if (res_hs) out_cnt_d = pop ? '0 : out_cnt_q + CntOne;
  end

  // Handshake outputs are held low while reset is asserted.
  always_comb begin
    s0_ready_o   = r0 & reset_n_i;
    s1_ready_o   = r1 & reset_n_i;
    filt_valid_o = fv & reset_n_i;
    filt_data_o  = gnt_q[0] ? s1_data_i : s0_data_i;
    filt_ready_o = res_ready_i & tag_nonempty & reset_n_i;
    res_valid_o  = res_v & reset_n_i;
    res_data_o   = filt_data_i;
    res_sid_o    = head_sid[0];
    res_first_o  = (out_cnt_q == '0);
    res_last_o   = (out_cnt_q == LastCnt);
    busy_o       = reset_n_i & ((state_q == STREAM) | tag_nonempty);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_q      <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule
